// File: rtl/usb_rx_pkg.sv
// Shared line-state encoding, receiver FSM states and framing thresholds for
// the full-speed USB receive front end.
package usb_rx_pkg;

    localparam logic [1:0] LS_SE0 = 2'd0;
    localparam logic [1:0] LS_J   = 2'd1;
    localparam logic [1:0] LS_K   = 2'd2;
    localparam logic [1:0] LS_SE1 = 2'd3;

    localparam logic [2:0] SYNC_MIN_ZEROS = 3'd5;
    localparam logic [2:0] STUFF_LIMIT    = 3'd6;
    localparam logic [2:0] ZERO_SAT       = 3'd7;

    // Four clocks per bit; phase 2 is the middle of the bit cell.
    localparam logic [1:0] SAMPLE_PHASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP
    } rx_state_t;

    function automatic logic is_jk(input logic [1:0] ls);
        return (ls == LS_J) || (ls == LS_K);
    endfunction

endpackage

// File: rtl/usb_rx_sync.sv
// Two-flop synchroniser on D+/D- followed by the line-state register.
// Every stage resets to J so no transition is seen coming out of reset.
module usb_rx_sync
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    output logic [1:0] line_state,
    output logic       line_change
);

    // Bit 1 carries D-, bit 0 carries D+, which gives the line-state encoding directly.
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_reg   <= LS_J;
            sync_reg   <= LS_J;
            line_state <= LS_J;
        end else begin
            meta_reg   <= {usb_n_rx, usb_p_rx};
            sync_reg   <= meta_reg;
            line_state <= sync_reg;
        end
    end

    // High in the cycle whose edge will load a new value into line_state.
    assign line_change = (sync_reg != line_state);

endmodule

// File: rtl/usb_rx_cdr.sv
// Full-speed USB receive front end: DPLL bit recovery, NRZI decode, SYNC and
// EOP framing, bit unstuffing, with registered strobes to the packet decoder.
module usb_rx_cdr
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    output logic [1:0] line_state,
    output logic       rx_bit_valid,
    output logic       rx_bit,
    output logic       pkt_start,
    output logic       pkt_end,
    output logic       rx_err
);

    logic       line_change;
    logic [1:0] phase_reg;
    logic       sample;
    logic       jk;
    logic       nrzi_bit;

    rx_state_t  state_reg, state_next;
    logic [2:0] zero_cnt_reg, zero_cnt_next;
    logic [2:0] ones_cnt_reg, ones_cnt_next;
    logic [1:0] prev_ls_reg, prev_ls_next;

    logic start_next, bit_valid_next, bit_next, end_next, err_next;
    logic start_reg, bit_valid_reg, bit_reg, end_reg, err_reg;

    usb_rx_sync u_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .usb_p_rx    (usb_p_rx),
        .usb_n_rx    (usb_n_rx),
        .line_state  (line_state),
        .line_change (line_change)
    );

    // Phase realigns on the same edge that loads a new line state, so the
    // strobe lands two clocks after every transition.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_reg <= 2'd0;
        end else if (line_change) begin
            phase_reg <= 2'd0;
        end else begin
            phase_reg <= phase_reg + 2'd1;
        end
    end

    assign sample   = (phase_reg == SAMPLE_PHASE);
    assign jk       = is_jk(line_state);
    assign nrzi_bit = (line_state == prev_ls_reg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            zero_cnt_reg  <= 3'd0;
            ones_cnt_reg  <= 3'd0;
            prev_ls_reg   <= LS_J;
            start_reg     <= 1'b0;
            bit_valid_reg <= 1'b0;
            bit_reg       <= 1'b0;
            end_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            zero_cnt_reg  <= zero_cnt_next;
            ones_cnt_reg  <= ones_cnt_next;
            prev_ls_reg   <= prev_ls_next;
            start_reg     <= start_next;
            bit_valid_reg <= bit_valid_next;
            bit_reg       <= bit_next;
            end_reg       <= end_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        zero_cnt_next = zero_cnt_reg;
        ones_cnt_next = ones_cnt_reg;
        prev_ls_next  = prev_ls_reg;
        if (sample) begin
            if (jk) begin
                prev_ls_next = line_state;
            end
            unique case (state_reg)
                ST_IDLE: begin
                    if (line_state == LS_K) begin
                        state_next    = ST_SYNC;
                        zero_cnt_next = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (!jk) begin
                        state_next = ST_IDLE;
                    end else if (!nrzi_bit) begin
                        zero_cnt_next = (zero_cnt_reg == ZERO_SAT) ? ZERO_SAT
                                                                   : zero_cnt_reg + 3'd1;
                    end else if (zero_cnt_reg >= SYNC_MIN_ZEROS) begin
                        state_next    = ST_DATA;
                        ones_cnt_next = 3'd0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (line_state == LS_SE1) begin
                        state_next = ST_IDLE;
                    end else if (line_state == LS_SE0) begin
                        state_next = ST_EOP;
                    end else if (ones_cnt_reg == STUFF_LIMIT) begin
                        if (nrzi_bit) begin
                            state_next = ST_IDLE;
                        end else begin
                            ones_cnt_next = 3'd0;
                        end
                    end else begin
                        ones_cnt_next = nrzi_bit ? ones_cnt_reg + 3'd1 : 3'd0;
                    end
                end
                ST_EOP: begin
                    if (line_state != LS_SE0) begin
                        state_next = ST_IDLE;
                    end
                end
            endcase
            // Decoding of the next packet always starts from an idle J reference.
            if (state_next == ST_IDLE) begin
                prev_ls_next = LS_J;
            end
        end
    end

    always_comb begin
        start_next     = 1'b0;
        bit_valid_next = 1'b0;
        bit_next       = 1'b0;
        end_next       = 1'b0;
        err_next       = 1'b0;
        if (sample) begin
            unique case (state_reg)
                ST_IDLE: begin
                end
                ST_SYNC: begin
                    if (line_state == LS_SE1) begin
                        err_next = 1'b1;
                    end else if (jk && nrzi_bit && (zero_cnt_reg >= SYNC_MIN_ZEROS)) begin
                        start_next = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (line_state == LS_SE1) begin
                        err_next = 1'b1;
                    end else if (jk) begin
                        if (ones_cnt_reg == STUFF_LIMIT) begin
                            err_next = nrzi_bit;
                        end else begin
                            bit_valid_next = 1'b1;
                            bit_next       = nrzi_bit;
                        end
                    end
                end
                ST_EOP: begin
                    if (line_state == LS_J) begin
                        end_next = 1'b1;
                    end else if (line_state != LS_SE0) begin
                        err_next = 1'b1;
                    end
                end
            endcase
        end
    end

    assign pkt_start    = start_reg;
    assign rx_bit_valid = bit_valid_reg;
    assign rx_bit       = bit_reg;
    assign pkt_end      = end_reg;
    assign rx_err       = err_reg;

endmodule

// File: tb/tb_usb_rx_cdr.sv
// Scoreboard bench for usb_rx_cdr: packets are built as line-state symbol
// lists, expected strobes are queued at build time and popped by a monitor.
module tb_usb_rx_cdr;

    localparam logic [1:0] SE0 = 2'd0;
    localparam logic [1:0] J   = 2'd1;
    localparam logic [1:0] K   = 2'd2;
    localparam logic [1:0] SE1 = 2'd3;

    localparam int EV_START = 1;
    localparam int EV_BIT0  = 2;
    localparam int EV_BIT1  = 3;
    localparam int EV_END   = 4;
    localparam int EV_ERR   = 5;
    localparam int EV_MULTI = 6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       usb_p_rx;
    logic       usb_n_rx;
    logic [1:0] line_state;
    logic       rx_bit_valid;
    logic       rx_bit;
    logic       pkt_start;
    logic       pkt_end;
    logic       rx_err;

    int         checks_total  = 0;
    int         checks_passed = 0;
    int         exp_q[$];
    logic [1:0] sym_q[$];
    logic [1:0] cur_lvl;
    string      cur_test = "reset";

    always #5 clk = ~clk;

    usb_rx_cdr dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .usb_p_rx     (usb_p_rx),
        .usb_n_rx     (usb_n_rx),
        .line_state   (line_state),
        .rx_bit_valid (rx_bit_valid),
        .rx_bit       (rx_bit),
        .pkt_start    (pkt_start),
        .pkt_end      (pkt_end),
        .rx_err       (rx_err)
    );

    task automatic check_eq(input string tag, input int observed, input int expected);
        checks_total++;
        if (observed == expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Monitor: every strobe cycle is one transaction, compared against the queue head.
    always @(negedge clk) begin
        int code;
        int hits;
        int want;
        hits = int'(rx_bit_valid) + int'(pkt_start) + int'(pkt_end) + int'(rx_err);
        code = 0;
        if (hits > 1)          code = EV_MULTI;
        else if (pkt_start)    code = EV_START;
        else if (rx_bit_valid) code = rx_bit ? EV_BIT1 : EV_BIT0;
        else if (pkt_end)      code = EV_END;
        else if (rx_err)       code = EV_ERR;
        if (code != 0) begin
            if (exp_q.size() == 0) begin
                $display("%s: event %0d with nothing expected", cur_test, code);
                check_eq({cur_test, "/unexpected_event"}, code, 0);
            end else begin
                want = exp_q.pop_front();
                $display("%s: event %0d expected %0d", cur_test, code, want);
                check_eq({cur_test, "/event"}, code, want);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic set_line(input logic [1:0] ls);
        usb_p_rx = ls[0];
        usb_n_rx = ls[1];
    endtask

    task automatic idle(input int n);
        set_line(J);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_nrzi(input bit b);
        if (!b) cur_lvl = (cur_lvl == J) ? K : J;
        sym_q.push_back(cur_lvl);
    endtask

    task automatic add_sync();
        cur_lvl = J;
        repeat (7) add_nrzi(1'b0);
        add_nrzi(1'b1);
        exp_q.push_back(EV_START);
    endtask

    // Transmitter model: LSB first, a 0 is stuffed after every run of six 1s.
    task automatic add_payload(input logic [7:0] data, input int nbits);
        int ones = 0;
        for (int i = 0; i < nbits; i++) begin
            add_nrzi(data[i]);
            exp_q.push_back(data[i] ? EV_BIT1 : EV_BIT0);
            ones = data[i] ? ones + 1 : 0;
            if (ones == 6) begin
                add_nrzi(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic add_eop();
        sym_q.push_back(SE0);
        sym_q.push_back(SE0);
        sym_q.push_back(J);
        exp_q.push_back(EV_END);
    endtask

    // Plays sym_q at 4 clocks per symbol. With jitter, edges 1,5,9.. are late
    // by one clock and edges 3,7,11.. early by one. rst_at >= 0 pulses reset
    // for one clock at the start of that symbol.
    task automatic drive_syms(input bit jitter, input int rst_at);
        int         shift[$];
        int         edge_idx = 0;
        int         dur;
        int         s;
        logic [1:0] prev = J;
        logic [1:0] sv;
        for (int j = 0; j < sym_q.size(); j++) begin
            s = 0;
            if (sym_q[j] != prev) begin
                if (jitter) s = (edge_idx % 4 == 1) ? 1 : ((edge_idx % 4 == 3) ? -1 : 0);
                edge_idx++;
            end
            shift.push_back(s);
            prev = sym_q[j];
        end
        shift.push_back(0);
        for (int j = 0; j < sym_q.size(); j++) begin
            dur = 4 + shift[j+1] - shift[j];
            sv = sym_q[j];
            set_line(sv);
            if (j == rst_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                check_eq("reset_mid/line_state", int'(line_state), int'(J));
                check_eq("reset_mid/outputs",
                         int'({rx_bit_valid, rx_bit, pkt_start, pkt_end, rx_err}), 0);
                reset_n = 1'b1;
                dur--;
            end
            repeat (dur) @(negedge clk);
        end
        sym_q.delete();
    endtask

    task automatic finish_test();
        idle(40);
        check_eq({cur_test, "/pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic good_packet(input string name, input logic [7:0] data, input bit jitter);
        cur_test = name;
        add_sync();
        add_payload(data, 8);
        add_eop();
        drive_syms(jitter, -1);
        finish_test();
    endtask

    initial begin
        reset_n = 1'b0;
        set_line(K);
        repeat (3) @(negedge clk);
        check_eq("reset/line_state", int'(line_state), int'(J));
        check_eq("reset/outputs", int'({rx_bit_valid, rx_bit, pkt_start, pkt_end, rx_err}), 0);
        set_line(J);
        reset_n = 1'b1;
        idle(20);
        check_eq("reset/idle_line_state", int'(line_state), int'(J));

        cur_test = "latency";
        set_line(K);
        repeat (2) @(negedge clk);
        check_eq("latency/after_2clk", int'(line_state), int'(J));
        @(negedge clk);
        check_eq("latency/after_3clk", int'(line_state), int'(K));
        @(negedge clk);
        finish_test();

        good_packet("nominal_a5", 8'hA5, 1'b0);
        good_packet("nominal_7e", 8'h7E, 1'b0);
        good_packet("stuff_ff", 8'hFF, 1'b0);

        cur_test = "stuff_error";
        add_sync();
        repeat (6) begin
            add_nrzi(1'b1);
            exp_q.push_back(EV_BIT1);
        end
        add_nrzi(1'b1);
        exp_q.push_back(EV_ERR);
        add_nrzi(1'b1);
        add_nrzi(1'b1);
        sym_q.push_back(SE0);
        sym_q.push_back(SE0);
        sym_q.push_back(J);
        drive_syms(1'b0, -1);
        finish_test();

        good_packet("jitter_a5", 8'hA5, 1'b1);
        good_packet("jitter_00", 8'h00, 1'b1);

        cur_test = "truncated_sync";
        cur_lvl = J;
        repeat (3) add_nrzi(1'b0);
        add_nrzi(1'b1);
        drive_syms(1'b0, -1);
        finish_test();
        good_packet("after_truncated", 8'hA5, 1'b0);

        cur_test = "se1_in_data";
        add_sync();
        add_payload(8'hA5, 4);
        sym_q.push_back(SE1);
        exp_q.push_back(EV_ERR);
        drive_syms(1'b0, -1);
        finish_test();
        good_packet("after_se1", 8'h3C, 1'b0);

        cur_test = "se0_then_k";
        add_sync();
        add_payload(8'hA5, 4);
        sym_q.push_back(SE0);
        sym_q.push_back(K);
        exp_q.push_back(EV_ERR);
        drive_syms(1'b0, -1);
        finish_test();
        good_packet("after_bad_eop", 8'hA5, 1'b0);

        // Reset at payload symbol 12: only SYNC and payload bits 0..2 get out.
        cur_test = "reset_abort";
        add_sync();
        add_payload(8'hA5, 8);
        add_eop();
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        drive_syms(1'b0, 12);
        finish_test();
        good_packet("after_reset", 8'hA5, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
